// File: rtl/fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fmul_pipe
// Purpose  : 3-stage pipelined IEEE-754-style multiplier with valid/ready
//            handshake. Denormals are flushed. Define FMUL_RNE_EN to get
//            round-to-nearest-even; otherwise the result is truncated.
// Revision : 1.0  initial release
// ============================================================================
module fmul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_result,
   output logic [TAG_W-1:0]     out_tag,
   output logic [2:0]           out_flags
);
   localparam int c_SW = EXP_W + 2;
   localparam int c_PW = 2 * (MAN_W + 1);
   localparam logic [c_SW-1:0] c_BIAS    = c_SW'((1 << (EXP_W - 1)) - 1);
   localparam logic [c_SW-1:0] c_EXP_MAX = c_SW'((1 << EXP_W) - 1);
   localparam logic [1:0] c_CLS_NORM = 2'd0;
   localparam logic [1:0] c_CLS_ZERO = 2'd1;
   localparam logic [1:0] c_CLS_INF  = 2'd2;
   localparam logic [1:0] c_CLS_NAN  = 2'd3;

   logic r_v1, r_v2, r_v3;
   logic w_adv1, w_adv2, w_adv3;

   assign w_adv3   = !r_v3 || out_ready;
   assign w_adv2   = !r_v2 || w_adv3;
   assign w_adv1   = !r_v1 || w_adv2;
   assign in_ready = w_adv1;

   // S1: unpack and classify
   logic             w_sa, w_sb;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_ma, w_mb;
   logic             w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
   logic [1:0]       w_cls;
   logic [c_SW-1:0]  w_exp_sum;

   assign {w_sa, w_ea, w_ma} = in_a;
   assign {w_sb, w_eb, w_mb} = in_b;
   assign w_a_zero  = (w_ea == '0);
   assign w_b_zero  = (w_eb == '0);
   assign w_a_inf   = (&w_ea) && (w_ma == '0);
   assign w_b_inf   = (&w_eb) && (w_mb == '0);
   assign w_a_nan   = (&w_ea) && (w_ma != '0);
   assign w_b_nan   = (&w_eb) && (w_mb != '0);
   assign w_exp_sum = c_SW'(w_ea) + c_SW'(w_eb) - c_BIAS;

   always_comb begin
      w_cls = c_CLS_NORM;
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
         w_cls = c_CLS_NAN;
      else if (w_a_inf || w_b_inf)
         w_cls = c_CLS_INF;
      else if (w_a_zero || w_b_zero)
         w_cls = c_CLS_ZERO;
   end

   logic             r_sign1, r_sign2;
   logic [c_SW-1:0]  r_exp1, r_exp2;
   logic [1:0]       r_cls1, r_cls2;
   logic [MAN_W:0]   r_ma1, r_mb1;
   logic [c_PW-1:0]  r_prod2;
   logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
   logic [EXP_W+MAN_W:0] r_result;
   logic [2:0]       r_flags;

   // S3: normalise, round, range-check and pack
   logic            w_top;
   logic [MAN_W-1:0] w_mant_t;
   logic [MAN_W:0]  w_mant_r;
   logic [c_SW-1:0] w_exp_n, w_exp_r;
   logic [EXP_W+MAN_W:0] w_res;
   logic [2:0]      w_flags;

   assign w_top    = r_prod2[c_PW-1];
   assign w_mant_t = w_top ? r_prod2[c_PW-2 -: MAN_W] : r_prod2[c_PW-3 -: MAN_W];
   assign w_exp_n  = r_exp2 + c_SW'(w_top);

`ifdef FMUL_RNE_EN
   logic w_guard, w_sticky, w_rnd_up;
   // sticky folds the round bit together with every lower product bit
   assign w_guard  = w_top ? r_prod2[c_PW-2-MAN_W] : r_prod2[c_PW-3-MAN_W];
   assign w_sticky = w_top ? (|r_prod2[c_PW-3-MAN_W:0]) : (|r_prod2[c_PW-4-MAN_W:0]);
   assign w_rnd_up = w_guard && (w_sticky || w_mant_t[0]);
   assign w_mant_r = {1'b0, w_mant_t} + (MAN_W+1)'(w_rnd_up);
`else
   logic w_unused_low;
   assign w_unused_low = ^r_prod2[c_PW-3-MAN_W:0];
   assign w_mant_r     = {1'b0, w_mant_t};
`endif

   assign w_exp_r = w_exp_n + c_SW'(w_mant_r[MAN_W]);

   always_comb begin
      w_res   = '0;
      w_flags = 3'b000;
      case (r_cls2)
         c_CLS_NAN: begin
            w_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags = 3'b100;
         end
         c_CLS_INF:  w_res = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         c_CLS_ZERO: w_res = {r_sign2, {(EXP_W+MAN_W){1'b0}}};
         default: begin
            if (!w_exp_r[c_SW-1] && (w_exp_r >= c_EXP_MAX)) begin
               w_res   = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               w_flags = 3'b010;
            end else if (w_exp_r[c_SW-1] || (w_exp_r == '0)) begin
               w_res   = {r_sign2, {(EXP_W+MAN_W){1'b0}}};
               w_flags = 3'b001;
            end else begin
               w_res = {r_sign2, w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_v3     <= 1'b0;
         r_result <= '0;
         r_flags  <= 3'b000;
         r_tag3   <= '0;
      end else begin
         if (w_adv1) r_v1 <= in_valid;
         if (w_adv2) r_v2 <= r_v1;
         if (w_adv3) r_v3 <= r_v2;
         if (w_adv3 && r_v2) begin
            r_result <= w_res;
            r_flags  <= w_flags;
            r_tag3   <= r_tag2;
         end
      end
   end

   // datapath stages carry no reset; their valid bits qualify them
   always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) begin
         r_sign1 <= w_sa ^ w_sb;
         r_exp1  <= w_exp_sum;
         r_cls1  <= w_cls;
         r_ma1   <= {1'b1, w_ma};
         r_mb1   <= {1'b1, w_mb};
         r_tag1  <= in_tag;
      end
      if (w_adv2 && r_v1) begin
         r_sign2 <= r_sign1;
         r_exp2  <= r_exp1;
         r_cls2  <= r_cls1;
         r_prod2 <= c_PW'(r_ma1) * c_PW'(r_mb1);
         r_tag2  <= r_tag1;
      end
   end

   assign out_valid  = r_v3;
   assign out_result = r_result;
   assign out_flags  = r_flags;
   assign out_tag    = r_tag3;

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_pipe
// Purpose  : directed self-checking bench for fmul_pipe (binary32 build).
// Revision : 1.0  initial release
// ============================================================================
module tb_fmul_pipe;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_result;
   logic [3:0]  in_tag, out_tag;
   logic [2:0]  out_flags;
   int          errors = 0;
   int          checks = 0;

   logic [31:0] va[8], vb[8], vr[8];
   logic [2:0]  vf[8];

   always #5 clk = ~clk;

   fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick;
         n++;
      end
      ok = out_valid;
   endtask

   function automatic logic [31:0] op_a(input int k);
      case (k)
         1: return 32'h3F800000;
         2: return 32'h40000000;
         3: return 32'h40400000;
         default: return 32'h40800000;
      endcase
   endfunction

   function automatic logic [31:0] op_r(input int k);
      case (k)
         1: return 32'h40000000;
         2: return 32'h40800000;
         3: return 32'h40C00000;
         default: return 32'h41000000;
      endcase
   endfunction

   task automatic load_vectors;
      va[0] = 32'h40400000; vb[0] = 32'h40000000; vr[0] = 32'h40C00000; vf[0] = 3'b000;
      va[1] = 32'h7F800000; vb[1] = 32'h00000000; vr[1] = 32'h7FC00000; vf[1] = 3'b100;
      va[2] = 32'hFF800000; vb[2] = 32'h40000000; vr[2] = 32'hFF800000; vf[2] = 3'b000;
      va[3] = 32'h00000001; vb[3] = 32'h3F800000; vr[3] = 32'h00000000; vf[3] = 3'b000;
      va[4] = 32'h7F000000; vb[4] = 32'h40000000; vr[4] = 32'h7F800000; vf[4] = 3'b010;
      va[5] = 32'h00800000; vb[5] = 32'h00800000; vr[5] = 32'h00000000; vf[5] = 3'b001;
      va[6] = 32'h3FC00000; vb[6] = 32'h3FC00000; vr[6] = 32'h40100000; vf[6] = 3'b000;
`ifdef FMUL_RNE_EN
      va[7] = 32'h3F800001; vb[7] = 32'h3FC00000; vr[7] = 32'h3FC00002; vf[7] = 3'b000;
`else
      va[7] = 32'h3F800001; vb[7] = 32'h3FC00000; vr[7] = 32'h3FC00001; vf[7] = 3'b000;
`endif
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_tag = '0;
      tick; tick;
      rst_n = 1'b1;
      checks++;
      if ({out_valid, out_result, out_tag, out_flags} !== 40'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b r=%h t=%h f=%b, expected all zero",
                  out_valid, out_result, out_tag, out_flags);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_latency;
      in_a = 32'h40400000; in_b = 32'h40000000; in_tag = 4'd5; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL lat_in_ready: got %b expected 1", in_ready);
      end
      tick;
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (out_valid !== (c == 3)) begin
            errors++;
            $display("FAIL lat_cycle%0d: out_valid got %b expected %b", c, out_valid, (c == 3));
         end
         if (c < 3) tick;
      end
      checks++;
      if ({out_result, out_flags, out_tag} !== {32'h40C00000, 3'b000, 4'd5}) begin
         errors++;
         $display("FAIL mul_3x2: got %h f=%b t=%h expected 40c00000 f=000 t=5",
                  out_result, out_flags, out_tag);
      end
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_drain: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_rounding;
      bit ok;
      logic [31:0] exp_r;
`ifdef FMUL_RNE_EN
      exp_r = 32'h3FC00002;
`else
      exp_r = 32'h3FC00001;
`endif
      issue(32'h3F800001, 32'h3FC00000, 4'd7);
      wait_out(ok);
      checks++;
      if (!ok || out_result !== exp_r || out_flags !== 3'b000) begin
         errors++;
         $display("FAIL round_tie: got %h f=%b expected %h f=000", out_result, out_flags, exp_r);
      end
      issue(32'hBF800000, 32'h40400000, 4'd8);
      wait_out(ok);
      checks++;
      if (!ok || out_result !== 32'hC0400000) begin
         errors++;
         $display("FAIL mul_neg: got %h expected c0400000", out_result);
      end
      tick;
   endtask

   task automatic test_specials;
      logic [31:0] a[6], b[6], r[6];
      logic [2:0]  f[6];
      bit ok;
      a[0] = 32'h7F800000; b[0] = 32'h00000000; r[0] = 32'h7FC00000; f[0] = 3'b100;
      a[1] = 32'hFF800000; b[1] = 32'h40000000; r[1] = 32'hFF800000; f[1] = 3'b000;
      a[2] = 32'h00000001; b[2] = 32'h3F800000; r[2] = 32'h00000000; f[2] = 3'b000;
      a[3] = 32'hFFA00000; b[3] = 32'h3F800000; r[3] = 32'h7FC00000; f[3] = 3'b100;
      a[4] = 32'hC0000000; b[4] = 32'h00000000; r[4] = 32'h80000000; f[4] = 3'b000;
      a[5] = 32'hFF800000; b[5] = 32'hFF800000; r[5] = 32'h7F800000; f[5] = 3'b000;
      for (int i = 0; i < 6; i++) begin
         issue(a[i], b[i], 4'(i));
         wait_out(ok);
         checks++;
         if (!ok || out_result !== r[i] || out_flags !== f[i]) begin
            errors++;
            $display("FAIL special%0d: got %h f=%b expected %h f=%b", i, out_result, out_flags, r[i], f[i]);
         end
         tick;
      end
   endtask

   task automatic test_range;
      logic [31:0] a[3], b[3], r[3];
      logic [2:0]  f[3];
      bit ok;
      a[0] = 32'h7F000000; b[0] = 32'h40000000; r[0] = 32'h7F800000; f[0] = 3'b010;
      a[1] = 32'h00800000; b[1] = 32'h00800000; r[1] = 32'h00000000; f[1] = 3'b001;
      a[2] = 32'hFF000000; b[2] = 32'h40000000; r[2] = 32'hFF800000; f[2] = 3'b010;
      for (int i = 0; i < 3; i++) begin
         issue(a[i], b[i], 4'(i));
         wait_out(ok);
         checks++;
         if (!ok || out_result !== r[i] || out_flags !== f[i]) begin
            errors++;
            $display("FAIL range%0d: got %h f=%b expected %h f=%b", i, out_result, out_flags, r[i], f[i]);
         end
         tick;
      end
   endtask

   task automatic test_back_to_back;
      int got = 0;
      int first = -1;
      int last = -1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         in_valid = (cyc < 4);
         in_a = op_a(cyc + 1); in_b = 32'h40000000; in_tag = 4'(cyc + 1);
         #1;
         if (out_valid) begin
            checks++;
            if (out_tag !== 4'(got + 1) || out_result !== op_r(got + 1)) begin
               errors++;
               $display("FAIL b2b_item%0d: got %h t=%h expected %h t=%0d",
                        got, out_result, out_tag, op_r(got + 1), got + 1);
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         tick;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 4 || first != 3 || last != 6) begin
         errors++;
         $display("FAIL b2b_timing: got count=%0d first=%0d last=%0d expected 4/3/6", got, first, last);
      end
   endtask

   task automatic test_backpressure;
      int sent = 1;
      int got = 0;
      int extra = 0;
      bit hs;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         in_valid = 1'b1; in_a = op_a(sent); in_b = 32'h40000000; in_tag = 4'(sent);
         #1;
         hs = in_ready;
         tick;
         if (hs) sent++;
      end
      #1;
      checks++;
      if (sent != 4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: got accepted=%0d in_ready=%b expected 3/0", sent - 1, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_result !== op_r(1)) begin
         errors++;
         $display("FAIL bp_hold: got v=%b t=%h r=%h expected 1/1/%h", out_valid, out_tag, out_result, op_r(1));
      end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         in_valid = (sent <= 4); in_a = op_a(sent); in_b = 32'h40000000; in_tag = 4'(sent);
         #1;
         hs = in_valid && in_ready;
         if (cyc == 0) begin
            checks++;
            if (hs !== 1'b1) begin
               errors++;
               $display("FAIL bp_full_accept: in_ready got %b expected 1", in_ready);
            end
         end
         if (out_valid) begin
            checks++;
            if (out_tag !== 4'(got + 1) || out_result !== op_r(got + 1)) begin
               errors++;
               $display("FAIL bp_order%0d: got %h t=%h expected %h t=%0d",
                        got, out_result, out_tag, op_r(got + 1), got + 1);
            end
            got++;
         end
         tick;
         if (hs) sent++;
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (out_valid) extra++;
         tick;
      end
      checks++;
      if (got != 4 || extra != 0) begin
         errors++;
         $display("FAIL bp_count: got results=%0d extra=%0d expected 4/0", got, extra);
      end
   endtask

   task automatic test_reset_midflight;
      int stale = 0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h40000000; in_tag = 4'd9;
      tick;
      in_tag = 4'd10;
      tick;
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (out_valid) stale++;
         tick;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL rst_stale: got %0d stale results expected 0", stale);
      end
   endtask

   task automatic test_stream;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      bit in_hs, out_hs, stalled;
      logic [38:0] held;
      stalled = 1'b0;
      held = '0;
      while (got < 1000 && cyc < 20000) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_a = va[sent % 8]; in_b = vb[sent % 8]; in_tag = 4'(sent % 16);
         #1;
         if (stalled) begin
            checks++;
            if (!out_valid || {out_result, out_flags, out_tag} !== held) begin
               errors++;
               $display("FAIL stream_stable: got v=%b %h expected held %h",
                        out_valid, {out_result, out_flags, out_tag}, held);
            end
         end
         in_hs  = in_valid && in_ready;
         out_hs = out_valid && out_ready;
         stalled = out_valid && !out_ready;
         held = {out_result, out_flags, out_tag};
         if (out_hs) begin
            checks++;
            if ({out_result, out_flags, out_tag} !== {vr[got % 8], vf[got % 8], 4'(got % 16)}) begin
               errors++;
               $display("FAIL stream_item%0d: got %h f=%b t=%h expected %h f=%b t=%h",
                        got, out_result, out_flags, out_tag, vr[got % 8], vf[got % 8], 4'(got % 16));
            end
            got++;
         end
         tick;
         if (in_hs) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 1000) begin
         errors++;
         $display("FAIL stream_count: got %0d results expected 1000", got);
      end
   endtask

   initial begin
      load_vectors;
      test_reset;
      test_latency;
      test_rounding;
      test_specials;
      test_range;
      test_back_to_back;
      test_backpressure;
      test_reset_midflight;
      test_stream;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
